way_select_ctrl: RTL and testbench
==================================

Name: way_select_ctrl

Overview:
- Per-request way-selection controller for the L2 set-associative array.
- Accepts a lookup request for a set and samples the tag-compare hit vector and valid vector.
- Returns a hit way, or on a miss a victim way (first invalid way, otherwise tree pseudo-LRU), and holds off new requests until the miss fill completes.
- Sits between the request front end and the tag/data arrays; owns the per-set PLRU state.

Parameters:
- WAYS, 8, associativity; power of two, >= 2
- SETS, 16, number of sets; power of two, >= 2

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- req_valid  input  1  lookup request present
- req_ready  output  1  controller can accept a request
- req_set  input  $clog2(SETS)  set index; captured on accept
- hit_vec  input  WAYS  tag-compare hits; valid the cycle after accept
- valid_vec  input  WAYS  line-valid bits; valid the cycle after accept
- fill_done  input  1  pulse: miss fill written into the victim way
- rsp_valid  output  1  one-cycle response pulse
- rsp_hit  output  1  1 = hit, 0 = miss
- rsp_way  output  $clog2(WAYS)  hit way or victim way
- rsp_multi  output  1  more than one hit bit set (error)
- hit_count  output  16  see Optional Feature
- miss_count  output  16  see Optional Feature

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values:
  - state = IDLE, req_ready = 1
  - rsp_valid, rsp_hit, rsp_way, rsp_multi = 0
  - all PLRU bits = 0; hit_count, miss_count = 0
- FSM states: IDLE, LOOKUP, RESOLVE, FILL_WAIT.
- Transitions:
  - IDLE: req_ready = 1. On req_valid, capture req_set and go to LOOKUP.
  - LOOKUP: req_ready = 0. Register hit_vec and valid_vec, go to RESOLVE.
  - RESOLVE: drive the response registers; rsp_valid = 1 for exactly this one cycle.
    - At least one hit: rsp_hit = 1, rsp_way = lowest-index set bit, PLRU touch(way), go to IDLE.
    - Zero hits: rsp_hit = 0, rsp_way = victim, go to FILL_WAIT. PLRU is not touched here.
  - FILL_WAIT: req_ready = 0. On fill_done, PLRU touch(victim held from RESOLVE), go to IDLE.
- Latency: accept at edge N -> rsp_valid high in cycle N+2. Hit throughput is one request per 3 cycles.
- Victim rule:
  - If any valid_vec bit is 0, victim = lowest-index invalid way.
  - Otherwise victim = PLRU walk.
- PLRU layout:
  - WAYS-1 bits per set, heap indexed: node i has children 2i+1 and 2i+2; root is node 0.
  - Walk: bit 0 -> go left, bit 1 -> go right. The path gives the way index MSB first.
- touch(w): every node on the path to w is set to point away from w (1 if w is in the left subtree, else 0). Only the captured set is modified.
- rsp_multi: 1 when popcount(hit_vec) > 1. It is treated as a hit on the lowest way.
- Holding: response outputs other than rsp_valid hold their values until the next RESOLVE.
- Boundary conditions:
  - fill_done outside FILL_WAIT is ignored.
  - req_valid outside IDLE is not accepted.
  - Reset in any state aborts immediately to the reset values. A pending fill is abandoned with no PLRU update.

Optional Feature:
- Macro: WAY_SELECT_STATS_EN.
- Defined:
  - hit_count increments on every RESOLVE hit; miss_count increments on every RESOLVE miss.
  - Both are 16-bit and saturate at 16'hFFFF; reset clears them.
- Undefined: no counter registers are built; hit_count and miss_count are tied to 0.

Test Plan (WAYS=8, SETS=16):
1. PLRU victim sequence.
   - Stimulus: after reset, request set 3 with valid_vec=8'hFF, hit_vec=0, then fill_done; then a second miss on set 3.
   - Response: rsp_hit=0, rsp_way=0 at N+2; the second miss gives rsp_way=4.
2. Hit.
   - Stimulus: set 5, hit_vec=8'b0010_0000.
   - Response: rsp_valid at N+2, rsp_hit=1, rsp_way=5, rsp_multi=0, req_ready=1 at N+3.
3. Invalid-way victim.
   - Stimulus: miss with valid_vec=8'b1111_0111.
   - Response: rsp_way=3; FSM stays in FILL_WAIT with req_ready=0 until fill_done.
4. Multi-hit.
   - Stimulus: hit_vec=8'b1000_0010.
   - Response: rsp_hit=1, rsp_way=1, rsp_multi=1.
5. Request and fill_done outside their states.
   - Stimulus: hold req_valid during FILL_WAIT; pulse fill_done while IDLE.
   - Response: the request is not accepted until the cycle after fill_done; the stray fill_done causes no state or PLRU change.
6. Reset mid-operation and stats.
   - Stimulus: assert reset during FILL_WAIT.
   - Response: req_ready=1 and all PLRU bits=0 after release.
   - Stimulus: with WAY_SELECT_STATS_EN defined, run 3 hits and 2 misses.
   - Response: hit_count=3, miss_count=2.

Source files
------------

// File: rtl/way_select_ctrl.sv
// Way-selection controller for the L2 set-associative array: hit way or victim way
// (first invalid way, else tree pseudo-LRU), with per-set PLRU state.
// Optional hit/miss statistics counters are built when WAY_SELECT_STATS_EN is defined.
module way_select_ctrl #(
    parameter int unsigned WAYS = 8,
    parameter int unsigned SETS = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [$clog2(SETS)-1:0] req_set,
    input  logic [WAYS-1:0]         hit_vec,
    input  logic [WAYS-1:0]         valid_vec,
    input  logic                    fill_done,
    output logic                    rsp_valid,
    output logic                    rsp_hit,
    output logic [$clog2(WAYS)-1:0] rsp_way,
    output logic                    rsp_multi,
    output logic [15:0]             hit_count,
    output logic [15:0]             miss_count
);

    localparam int unsigned WW = $clog2(WAYS);
    localparam int unsigned SW = $clog2(SETS);

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        RESOLVE,
        FILL_WAIT
    } state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   set_q, set_d;
    logic            req_ready_q, req_ready_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            rsp_hit_q, rsp_hit_d;
    logic [WW-1:0]   rsp_way_q, rsp_way_d;
    logic            rsp_multi_q, rsp_multi_d;
    logic [WAYS-2:0] plru_q [SETS];
    logic [WAYS-2:0] plru_d [SETS];

    logic [WW-1:0]   first_hit;
    logic [WW-1:0]   first_invalid;
    logic            any_hit;
    logic            any_invalid;
    logic            multi_hit;
    logic [WW-1:0]   victim;

    // Walk the heap-indexed tree: 0 = left, 1 = right; path bits form the way MSB first.
    function automatic logic [WW-1:0] plru_walk(input logic [WAYS-2:0] bits);
        logic [WW-1:0] node;
        logic [WW-1:0] way;
        node = '0;
        way  = '0;
        for (int unsigned l = 0; l < WW; l++) begin
            way  = (way << 1) | WW'(bits[node]);
            node = (node << 1) + WW'(1) + WW'(bits[node]);
        end
        return way;
    endfunction

    function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] bits,
                                                   input logic [WW-1:0]   way);
        logic [WAYS-2:0] r;
        logic [WW-1:0]   node;
        logic [WW-1:0]   w;
        logic            b;
        r    = bits;
        node = '0;
        w    = way;
        for (int unsigned l = 0; l < WW; l++) begin
            b       = w[WW-1];
            r[node] = ~b;
            node    = (node << 1) + WW'(1) + WW'(b);
            w       = w << 1;
        end
        return r;
    endfunction

    always_comb begin
        first_hit     = '0;
        first_invalid = '0;
        for (int unsigned i = WAYS; i > 0; i--) begin
            if (hit_vec[i-1])    first_hit     = WW'(i - 1);
            if (!valid_vec[i-1]) first_invalid = WW'(i - 1);
        end
        any_hit     = |hit_vec;
        any_invalid = ~&valid_vec;
        multi_hit   = (hit_vec & (hit_vec - WAYS'(1))) != '0;
        victim      = any_invalid ? first_invalid : plru_walk(plru_q[set_q]);
    end

    always_comb begin
        state_d     = state_q;
        set_d       = set_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = 1'b0;
        rsp_hit_d   = rsp_hit_q;
        rsp_way_d   = rsp_way_q;
        rsp_multi_d = rsp_multi_q;
        plru_d      = plru_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    set_d       = req_set;
                    req_ready_d = 1'b0;
                    state_d     = LOOKUP;
                end
            end
            // Response registers load as the vectors are sampled so rsp_valid is high during RESOLVE.
            LOOKUP: begin
                rsp_valid_d = 1'b1;
                rsp_hit_d   = any_hit;
                rsp_multi_d = multi_hit;
                rsp_way_d   = any_hit ? first_hit : victim;
                state_d     = RESOLVE;
            end
            RESOLVE: begin
                if (rsp_hit_q) begin
                    plru_d[set_q] = plru_touch(plru_q[set_q], rsp_way_q);
                    req_ready_d   = 1'b1;
                    state_d       = IDLE;
                end else begin
                    state_d = FILL_WAIT;
                end
            end
            FILL_WAIT: begin
                if (fill_done) begin
                    plru_d[set_q] = plru_touch(plru_q[set_q], rsp_way_q);
                    req_ready_d   = 1'b1;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            set_q       <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_hit_q   <= 1'b0;
            rsp_way_q   <= '0;
            rsp_multi_q <= 1'b0;
            for (int unsigned s = 0; s < SETS; s++) begin
                plru_q[s] <= '0;
            end
        end else begin
            state_q     <= state_d;
            set_q       <= set_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_hit_q   <= rsp_hit_d;
            rsp_way_q   <= rsp_way_d;
            rsp_multi_q <= rsp_multi_d;
            plru_q      <= plru_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_hit   = rsp_hit_q;
    assign rsp_way   = rsp_way_q;
    assign rsp_multi = rsp_multi_q;

`ifdef WAY_SELECT_STATS_EN
    logic [15:0] hit_cnt_q, hit_cnt_d;
    logic [15:0] miss_cnt_q, miss_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (state_q == RESOLVE) begin
            if (rsp_hit_q && hit_cnt_q != 16'hFFFF)    hit_cnt_d  = hit_cnt_q + 16'd1;
            if (!rsp_hit_q && miss_cnt_q != 16'hFFFF)  miss_cnt_d = miss_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_way_select_ctrl.sv
// Directed self-checking bench for way_select_ctrl (WAYS=8, SETS=16): vector table
// of lookups with hand-computed PLRU victims, plus reset/boundary sequences.
module tb_way_select_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_set;
    logic [7:0]  hit_vec;
    logic [7:0]  valid_vec;
    logic        fill_done;
    logic        rsp_valid;
    logic        rsp_hit;
    logic [2:0]  rsp_way;
    logic        rsp_multi;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    int n_checks = 0;
    int n_pass   = 0;

    way_select_ctrl #(.WAYS(8), .SETS(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_set    (req_set),
        .hit_vec    (hit_vec),
        .valid_vec  (valid_vec),
        .fill_done  (fill_done),
        .rsp_valid  (rsp_valid),
        .rsp_hit    (rsp_hit),
        .rsp_way    (rsp_way),
        .rsp_multi  (rsp_multi),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] set;
        logic [7:0] hit;
        logic [7:0] valid;
        logic       exp_hit;
        logic [2:0] exp_way;
        logic       exp_multi;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // One lookup from IDLE; on a miss optionally completes the fill.
    task automatic do_req(input string tag, input logic [3:0] s, input logic [7:0] h,
                          input logic [7:0] v, input logic eh, input logic [2:0] ew,
                          input logic em, input bit do_fill);
        @(negedge clk);
        check({tag, "_ready_idle"}, {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_set   = s;
        @(negedge clk);
        req_valid = 1'b0;
        check({tag, "_ready_lookup"}, {31'd0, req_ready}, 32'd0);
        hit_vec   = h;
        valid_vec = v;
        @(negedge clk);
        check({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
        check({tag, "_rsp_hit"},   {31'd0, rsp_hit},   {31'd0, eh});
        check({tag, "_rsp_way"},   {29'd0, rsp_way},   {29'd0, ew});
        check({tag, "_rsp_multi"}, {31'd0, rsp_multi}, {31'd0, em});
        hit_vec   = '0;
        valid_vec = '0;
        @(negedge clk);
        check({tag, "_rsp_pulse"}, {31'd0, rsp_valid}, 32'd0);
        check({tag, "_way_held"},  {29'd0, rsp_way},   {29'd0, ew});
        if (eh) begin
            check({tag, "_ready_after_hit"}, {31'd0, req_ready}, 32'd1);
        end else begin
            check({tag, "_ready_fill_wait"}, {31'd0, req_ready}, 32'd0);
            if (do_fill) begin
                fill_done = 1'b1;
                @(negedge clk);
                fill_done = 1'b0;
                check({tag, "_ready_after_fill"}, {31'd0, req_ready}, 32'd1);
            end
        end
    endtask

    initial begin
        logic [15:0] exp_hits;
        logic [15:0] exp_misses;

        reset     = 1'b1;
        req_valid = 1'b0;
        req_set   = '0;
        hit_vec   = '0;
        valid_vec = '0;
        fill_done = 1'b0;

        vecs[0]  = '{4'd3,  8'h00, 8'hFF, 1'b0, 3'd0, 1'b0};
        vecs[1]  = '{4'd3,  8'h00, 8'hFF, 1'b0, 3'd4, 1'b0};
        vecs[2]  = '{4'd5,  8'h20, 8'hFF, 1'b1, 3'd5, 1'b0};
        vecs[3]  = '{4'd7,  8'h00, 8'hF7, 1'b0, 3'd3, 1'b0};
        vecs[4]  = '{4'd2,  8'h82, 8'hFF, 1'b1, 3'd1, 1'b1};
        vecs[5]  = '{4'd3,  8'h00, 8'hFF, 1'b0, 3'd2, 1'b0};
        vecs[6]  = '{4'd3,  8'h00, 8'hFF, 1'b0, 3'd6, 1'b0};
        vecs[7]  = '{4'd3,  8'h01, 8'hFF, 1'b1, 3'd0, 1'b0};
        vecs[8]  = '{4'd3,  8'h00, 8'hFF, 1'b0, 3'd5, 1'b0};
        vecs[9]  = '{4'd0,  8'h00, 8'hFE, 1'b0, 3'd0, 1'b0};
        vecs[10] = '{4'd15, 8'hFF, 8'hFF, 1'b1, 3'd0, 1'b1};
        vecs[11] = '{4'd9,  8'h00, 8'h00, 1'b0, 3'd0, 1'b0};
        vecs[12] = '{4'd1,  8'h80, 8'hFF, 1'b1, 3'd7, 1'b0};

        @(negedge clk);
        @(negedge clk);
        check("reset_ready",     {31'd0, req_ready}, 32'd1);
        check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset_rsp_hit",   {31'd0, rsp_hit},   32'd0);
        check("reset_rsp_way",   {29'd0, rsp_way},   32'd0);
        check("reset_rsp_multi", {31'd0, rsp_multi}, 32'd0);
        check("reset_hit_count", {16'd0, hit_count}, 32'd0);
        check("reset_miss_count", {16'd0, miss_count}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 13; i++) begin
            do_req($sformatf("vec%0d", i), vecs[i].set, vecs[i].hit, vecs[i].valid,
                   vecs[i].exp_hit, vecs[i].exp_way, vecs[i].exp_multi, 1'b1);
        end

        // Stray fill_done while idle must not move the FSM.
        @(negedge clk);
        fill_done = 1'b1;
        @(negedge clk);
        fill_done = 1'b0;
        check("stray_fill_ready", {31'd0, req_ready}, 32'd1);
        check("stray_fill_rsp",   {31'd0, rsp_valid}, 32'd0);

        // Miss on set 3, then hold a request through FILL_WAIT.
        do_req("hold_miss", 4'd3, 8'h00, 8'hFF, 1'b0, 3'd3, 1'b0, 1'b0);
        req_valid = 1'b1;
        req_set   = 4'd4;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("hold_ready_%0d", c), {31'd0, req_ready}, 32'd0);
            check($sformatf("hold_rsp_%0d", c),   {31'd0, rsp_valid}, 32'd0);
        end
        fill_done = 1'b1;
        @(negedge clk);
        fill_done = 1'b0;
        check("hold_ready_after_fill", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        check("hold_accepted", {31'd0, req_ready}, 32'd0);
        hit_vec   = 8'h08;
        valid_vec = 8'hFF;
        @(negedge clk);
        check("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("hold_rsp_hit",   {31'd0, rsp_hit},   32'd1);
        check("hold_rsp_way",   {29'd0, rsp_way},   32'd3);
        hit_vec   = '0;
        valid_vec = '0;
        @(negedge clk);

        // Fill touched way 3, so the next set-3 victim is 7; abort that fill with reset.
        do_req("pre_reset", 4'd3, 8'h00, 8'hFF, 1'b0, 3'd7, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        check("midrst_ready",     {31'd0, req_ready}, 32'd1);
        check("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("midrst_rsp_way",   {29'd0, rsp_way},   32'd0);
        check("midrst_hit_count", {16'd0, hit_count}, 32'd0);
        check("midrst_miss_count", {16'd0, miss_count}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        do_req("post_rst_miss1", 4'd3, 8'h00, 8'hFF, 1'b0, 3'd0, 1'b0, 1'b1);
        do_req("post_rst_hit1",  4'd5, 8'h02, 8'hFF, 1'b1, 3'd1, 1'b0, 1'b1);
        do_req("post_rst_hit2",  4'd6, 8'h40, 8'hFF, 1'b1, 3'd6, 1'b0, 1'b1);
        do_req("post_rst_hit3",  4'd7, 8'h0C, 8'hFF, 1'b1, 3'd2, 1'b1, 1'b1);
        do_req("post_rst_miss2", 4'd3, 8'h00, 8'hFF, 1'b0, 3'd4, 1'b0, 1'b1);

`ifdef WAY_SELECT_STATS_EN
        exp_hits   = 16'd3;
        exp_misses = 16'd2;
`else
        exp_hits   = 16'd0;
        exp_misses = 16'd0;
`endif
        @(negedge clk);
        check("stats_hit_count",  {16'd0, hit_count},  {16'd0, exp_hits});
        check("stats_miss_count", {16'd0, miss_count}, {16'd0, exp_misses});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
